// File: rtl/conv_sched_pkg.sv
// Shared types and default parameters for the convolution layer scheduler.
package conv_sched_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 16;
  localparam int unsigned SCALE_WIDTH_DEF = 4;
  localparam int unsigned PIPE_LAT_DEF    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_WSET   = 3'd2,
    S_ACCUM  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register that turns pixel-final beats into MAC output strobes.
module valid_delay_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic valid,
  output logic strobe,
  output logic empty
);

  logic [DEPTH-1:0] stage_q;

  // empty means nothing remains in flight once this cycle's strobe has been emitted
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clear) stage_q <= '0;
        else       stage_q <= valid;
      end
      assign empty = 1'b1;
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (clear) stage_q <= '0;
        else       stage_q <= {stage_q[DEPTH-2:0], valid};
      end
      assign empty = ~|stage_q[DEPTH-2:0];
    end
  endgenerate

  assign strobe = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer sequencer: walks oc groups, pixels and ic groups, and handshakes
// weight loads and data beats into the MAC array.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int unsigned PIPE_LAT    = PIPE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [CNT_WIDTH-1:0]   cfg_ic_groups,
  input  logic [CNT_WIDTH-1:0]   cfg_pixels,
  input  logic [CNT_WIDTH-1:0]   cfg_oc_groups,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  output logic                   busy,
  output logic                   wt_req,
  input  logic                   wt_ack,
  output logic                   mac_weight_valid,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   mac_data_valid,
  output logic                   mac_adder_rst,
  output logic [SCALE_WIDTH-1:0] mac_scale,
  output logic                   out_strobe,
  output logic                   done
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] ic_q, px_q, oc_q;
  logic [CNT_WIDTH-1:0] ic_last_q, px_last_q, oc_last_q;
  logic                 zero_layer_q;
  logic                 start_ok, beat, pixel_final, last_pixel, last_group, line_empty;

  assign start_ok    = (state_q == S_IDLE) && cfg_start;
  assign beat        = src_valid && src_ready;
  assign pixel_final = beat && (ic_q == ic_last_q);
  assign last_pixel  = (px_q == px_last_q);
  assign last_group  = zero_layer_q || (oc_q == oc_last_q);

  assign mac_data_valid = beat;
  assign mac_adder_rst  = beat && (ic_q == '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A zero-count layer routes through DRAIN (with an empty delay line) so done lands at T+2
  // without ever raising wt_req.
  always_comb begin
    // NOTE: defaulting every combinational output first prevents latch inference.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = ((cfg_pixels == '0) || (cfg_oc_groups == '0)) ? S_DRAIN : S_LOAD_W;
        end
      end
      S_LOAD_W: if (wt_ack) state_d = S_WSET;
      S_WSET:   state_d = S_ACCUM;
      S_ACCUM:  if (pixel_final && last_pixel) state_d = S_DRAIN;
      S_DRAIN:  if (line_empty) state_d = last_group ? S_DONE : S_LOAD_W;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = 1'b1;
    wt_req           = 1'b0;
    mac_weight_valid = 1'b0;
    src_ready        = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      S_IDLE:   busy             = 1'b0;
      S_LOAD_W: wt_req           = 1'b1;
      S_WSET:   mac_weight_valid = 1'b1;
      S_ACCUM:  src_ready        = 1'b1;
      S_DONE:   done             = 1'b1;
      default:  ;
    endcase
  end

  // Layer configuration, latched as terminal counts; an ic_groups of 0 behaves as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_last_q    <= '0;
      px_last_q    <= '0;
      oc_last_q    <= '0;
      zero_layer_q <= 1'b0;
      mac_scale    <= '0;
    end else if (start_ok) begin
      ic_last_q    <= (cfg_ic_groups == '0) ? '0 : cfg_ic_groups - ONE;
      px_last_q    <= cfg_pixels - ONE;
      oc_last_q    <= cfg_oc_groups - ONE;
      zero_layer_q <= (cfg_pixels == '0) || (cfg_oc_groups == '0);
      mac_scale    <= cfg_scale;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q <= '0;
      px_q <= '0;
      oc_q <= '0;
    end else if (start_ok) begin
      ic_q <= '0;
      px_q <= '0;
      oc_q <= '0;
    end else if (beat) begin
      if (pixel_final) begin
        ic_q <= '0;
        px_q <= px_q + ONE;
      end else begin
        ic_q <= ic_q + ONE;
      end
    end else if ((state_q == S_DRAIN) && (state_d == S_LOAD_W)) begin
      oc_q <= oc_q + ONE;
      px_q <= '0;
    end
  end

  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk    (clk),
    .clear  (rst),
    .valid  (pixel_final),
    .strobe (out_strobe),
    .empty  (line_empty)
  );

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: a vector table of whole layers plus hand-written
// sequences for start-while-busy and mid-layer reset.
module tb_conv_layer_sched;

  localparam int CW  = 16;
  localparam int SW  = 4;
  localparam int LAT = 4;

  logic          clk, rst, cfg_start;
  logic [CW-1:0] cfg_ic_groups, cfg_pixels, cfg_oc_groups;
  logic [SW-1:0] cfg_scale;
  logic          busy, wt_req, wt_ack, mac_weight_valid, src_valid, src_ready;
  logic          mac_data_valid, mac_adder_rst, out_strobe, done;
  logic [SW-1:0] mac_scale;

  conv_layer_sched #(.CNT_WIDTH(CW), .SCALE_WIDTH(SW), .PIPE_LAT(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_ic_groups    (cfg_ic_groups),
    .cfg_pixels       (cfg_pixels),
    .cfg_oc_groups    (cfg_oc_groups),
    .cfg_scale        (cfg_scale),
    .busy             (busy),
    .wt_req           (wt_req),
    .wt_ack           (wt_ack),
    .mac_weight_valid (mac_weight_valid),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .mac_data_valid   (mac_data_valid),
    .mac_adder_rst    (mac_adder_rst),
    .mac_scale        (mac_scale),
    .out_strobe       (out_strobe),
    .done             (done)
  );

  typedef struct {
    int ic, pix, oc, scale;
    int src_mode;   // 0 idle, 1 tied high, 2 random 50%
    int ack_delay;  // wt_req cycles before wt_ack
    int beats, rsts, strobes, wv, wtreq;
    int done_lat;   // done cycle minus start cycle, -1 when stimulus is random
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus controls written only by the main process.
  int src_mode = 0, ack_delay = 0, cur_ic = 1, clr_seq = 0, start_cyc = 0;

  // Monitor statistics written only by the monitor process.
  int beats, rst_cnt, strobes, wv, done_cnt, done_cyc, wtreq_cnt;
  int first_ack, first_ready, last_beat, strobe_err, rst_err, wv_err, pend;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input drivers: data beats and the weight-bus acknowledge.
  initial begin
    int req_age;
    req_age   = 0;
    src_valid = 0;
    wt_ack    = 0;
    forever begin
      @(posedge clk);
      #1;
      src_valid = (src_mode == 1) ? 1'b1 : (src_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wt_req) begin
        wt_ack = (req_age >= ack_delay);
        req_age++;
      end else begin
        wt_ack  = 0;
        req_age = 0;
      end
    end
  end

  // Monitor with a reference model of adder resets and expected strobe cycles.
  initial begin
    int last_seq, m_ic, last_final, has_final;
    int exp_q[$];
    last_seq = -1;
    forever begin
      @(negedge clk);
      if (clr_seq != last_seq) begin
        last_seq = clr_seq;
        beats = 0; rst_cnt = 0; strobes = 0; wv = 0; done_cnt = 0; done_cyc = -1;
        wtreq_cnt = 0; first_ack = -1; first_ready = -1; last_beat = -1;
        strobe_err = 0; rst_err = 0; wv_err = 0; m_ic = 0; has_final = 0; last_final = 0;
        exp_q.delete();
      end
      if (mac_data_valid) begin
        beats++;
        last_beat = cyc;
        if (mac_adder_rst != (m_ic == 0)) rst_err++;
        if (m_ic == cur_ic - 1) begin
          m_ic = 0;
          exp_q.push_back(cyc + LAT);
          last_final = cyc;
          has_final  = 1;
        end else begin
          m_ic++;
        end
      end else if (mac_adder_rst) begin
        rst_err++;
      end
      if (mac_adder_rst) rst_cnt++;
      if (out_strobe) begin
        strobes++;
        if (exp_q.size() == 0) strobe_err++;
        else begin
          if (exp_q[0] != cyc) strobe_err++;
          void'(exp_q.pop_front());
        end
      end
      pend = exp_q.size();
      if (mac_weight_valid) begin
        wv++;
        if ((has_final != 0) && (cyc <= last_final + LAT)) wv_err++;
      end
      if (wt_req) wtreq_cnt++;
      if (wt_ack && first_ack < 0) first_ack = cyc;
      if (src_ready && first_ready < 0) first_ready = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int ic, input int pix, input int oc, input int sc);
    cfg_ic_groups = ic[CW-1:0];
    cfg_pixels    = pix[CW-1:0];
    cfg_oc_groups = oc[CW-1:0];
    cfg_scale     = sc[SW-1:0];
    start_cyc     = cyc;
    cfg_start     = 1;
    tick();
    cfg_start     = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic prep(input int ic, input int mode, input int dly);
    cur_ic    = (ic == 0) ? 1 : ic;
    src_mode  = mode;
    ack_delay = dly;
    clr_seq++;
  endtask

  vec_t vecs [6];

  initial begin
    //           ic pix oc sc mode dly beats rsts str wv req lat
    vecs[0] = '{1, 1, 1, 3,  1, 0, 1,  1, 1, 1, 1, 8};
    vecs[1] = '{3, 4, 2, 7,  2, 0, 24, 8, 8, 2, 2, -1};
    vecs[2] = '{2, 2, 1, 1,  1, 4, 4,  2, 2, 1, 5, 15};
    vecs[3] = '{2, 0, 3, 2,  1, 0, 0,  0, 0, 0, 0, 2};
    vecs[4] = '{0, 2, 2, 15, 1, 0, 4,  4, 4, 2, 2, 17};
    vecs[5] = '{1, 3, 0, 4,  1, 0, 0,  0, 0, 0, 0, 2};

    rst = 1; cfg_start = 0;
    cfg_ic_groups = '0; cfg_pixels = '0; cfg_oc_groups = '0; cfg_scale = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_wt_req", int'(wt_req), 0);
    check("rst_wvalid", int'(mac_weight_valid), 0);
    check("rst_src_ready", int'(src_ready), 0);
    check("rst_mac_scale", int'(mac_scale), 0);
    check("rst_out_strobe", int'(out_strobe), 0);
    check("rst_done", int'(done), 0);
    rst = 0;
    tick();

    for (int i = 0; i < 6; i++) begin
      prep(vecs[i].ic, vecs[i].src_mode, vecs[i].ack_delay);
      start_layer(vecs[i].ic, vecs[i].pix, vecs[i].oc, vecs[i].scale);
      check($sformatf("v%0d_busy_t1", i), int'(busy), 1);
      wait_done();
      src_mode = 0;
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_beats", i), beats, vecs[i].beats);
      check($sformatf("v%0d_adder_rst", i), rst_cnt, vecs[i].rsts);
      check($sformatf("v%0d_strobes", i), strobes, vecs[i].strobes);
      check($sformatf("v%0d_wvalid", i), wv, vecs[i].wv);
      check($sformatf("v%0d_wt_req_cycles", i), wtreq_cnt, vecs[i].wtreq);
      check($sformatf("v%0d_strobe_timing", i), strobe_err + pend, 0);
      check($sformatf("v%0d_adder_rst_pos", i), rst_err, 0);
      check($sformatf("v%0d_wvalid_in_flight", i), wv_err, 0);
      check($sformatf("v%0d_mac_scale", i), int'(mac_scale), vecs[i].scale);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      if (vecs[i].done_lat >= 0)
        check($sformatf("v%0d_done_lat", i), done_cyc - start_cyc, vecs[i].done_lat);
      if (vecs[i].beats > 0) begin
        check($sformatf("v%0d_done_after_beat", i), done_cyc - last_beat, LAT + 1);
        check($sformatf("v%0d_ready_after_ack", i), first_ready - first_ack, 2);
      end
    end

    // cfg_start pulsed during ACCUM must be ignored.
    prep(2, 1, 0);
    start_layer(2, 2, 1, 6);
    while (cyc < start_cyc + 4) tick();
    cfg_pixels = 16'd9;
    cfg_start  = 1;
    tick();
    cfg_start  = 0;
    wait_done();
    repeat (10) tick();
    src_mode = 0;
    check("busy_start_done_lat", done_cyc - start_cyc, 11);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_beats", beats, 4);
    check("busy_start_strobes", strobes, 2);
    check("busy_start_wt_req", wtreq_cnt, 1);
    check("busy_start_scale", int'(mac_scale), 6);

    // Reset mid-ACCUM with two pixel strobes still in the delay line.
    prep(1, 1, 0);
    start_layer(1, 8, 1, 11);
    while (cyc < start_cyc + 4) tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_beats_before", beats, 2);
    check("mid_rst_outputs", int'({busy, wt_req, mac_weight_valid, src_ready,
                                   mac_data_valid, mac_adder_rst, out_strobe, done}), 0);
    check("mid_rst_scale", int'(mac_scale), 0);
    src_mode = 0;
    clr_seq++;
    repeat (12) tick();
    check("mid_rst_no_strobes", strobes, 0);
    check("mid_rst_no_done", done_cnt, 0);

    prep(1, 1, 0);
    start_layer(1, 1, 1, 9);
    wait_done();
    src_mode = 0;
    check("post_rst_done_lat", done_cyc - start_cyc, 8);
    check("post_rst_strobes", strobes, 1);
    check("post_rst_strobe_timing", strobe_err + pend, 0);
    check("post_rst_scale", int'(mac_scale), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
